ex_mem_stage: RTL and testbench

- EX/MEM pipeline stage directly downstream of ALU32Bit.
- Captures ALUResult/Zero plus EX-stage control and resolves conditional branches from Zero.
- Issues a one-cycle PC redirect and squashes wrong-path instructions still in flight upstream.
- Holds its register under memory-stage stall via a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/branch_resolve.sv | 21 ++
 rtl/ex_mem_stage.sv | 146 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: branch encodings, ALU control codes,
// EX/MEM control bundle and the squash FSM states.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLEZ = 3'd4,
        BR_J    = 3'd5
    } br_type_e;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_BEQ  = 6'b000100;
    localparam logic [5:0] ALU_BNE  = 6'b000101;
    localparam logic [5:0] ALU_BGTZ = 6'b000111;
    localparam logic [5:0] ALU_BLEZ = 6'b000110;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/branch_resolve.sv
// Branch decision from the ALU flag: Zero already encodes the per-type
// condition, so conditional types simply follow it and J always takes.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [2:0] branch_type_i,
    input  logic       zero_i,
    output logic       take_o
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        take_o = 1'b0;
        case (branch_type_i)
            BR_BEQ, BR_BNE, BR_BGTZ, BR_BLEZ: take_o = zero_i;
            BR_J:                             take_o = 1'b1;
            default:                          take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, one-cycle PC redirect,
// wrong-path squash FSM and a saturating taken-branch counter.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned SQUASH_DEPTH = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ExValid,
    output logic             ExReady,
    input  logic [31:0]      ALUResult,
    input  logic             Zero,
    input  logic [2:0]       BranchType,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      StoreData,
    input  logic [4:0]       WriteRegIn,
    input  logic             RegWriteIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic             MemToRegIn,
    input  logic             MemStall,
    output logic             MemValid,
    output logic [31:0]      MemAddr,
    output logic [31:0]      MemWData,
    output logic [4:0]       WriteReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             Redirect,
    output logic [31:0]      RedirectPC,
    output logic [CNT_W-1:0] TakenCount
);

    localparam int unsigned SQ_W = 3;

    state_e            state_q, state_d;
    logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d, ctrl_in;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        wreg_q, wreg_d;
    logic              redirect_q, redirect_d;
    logic [31:0]       redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic br_take;
    logic accept;
    logic taken;
    logic squash_entry;

    branch_resolve u_branch_resolve (
        .branch_type_i (BranchType),
        .zero_i        (Zero),
        .take_o        (br_take)
    );

    assign accept       = ExValid & ~MemStall;
    assign taken        = accept & (state_q == RUN) & br_take;
    assign squash_entry = accept & (state_q == SQUASH);
    assign ctrl_in      = '{reg_write: RegWriteIn, mem_read: MemReadIn,
                            mem_write: MemWriteIn, mem_to_reg: MemToRegIn};

    always_comb begin
        state_d     = state_q;
        sq_cnt_d    = sq_cnt_q;
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wreg_d      = wreg_q;
        redir_pc_d  = redir_pc_q;
        taken_cnt_d = taken_cnt_q;
        // Redirect is rebuilt every edge, so a stall can never re-issue it.
        redirect_d  = 1'b0;

        if (!MemStall) begin
            valid_d = ExValid & (state_q == RUN);
            ctrl_d  = valid_d ? ctrl_in : '0;
            if (ExValid) begin
                addr_d  = ALUResult;
                wdata_d = StoreData;
                wreg_d  = WriteRegIn;
            end
        end

        if (taken) begin
            redirect_d = 1'b1;
            redir_pc_d = BranchTarget;
            if (taken_cnt_q != '1) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
            state_d  = SQUASH;
            sq_cnt_d = SQ_W'(SQUASH_DEPTH);
        end else if (squash_entry) begin
            sq_cnt_d = sq_cnt_q - SQ_W'(1);
            if (sq_cnt_q == SQ_W'(1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= RUN;
            sq_cnt_q    <= '0;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wreg_q      <= '0;
            redirect_q  <= 1'b0;
            redir_pc_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wreg_q      <= wreg_d;
            redirect_q  <= redirect_d;
            redir_pc_q  <= redir_pc_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign ExReady    = ~MemStall;
    assign MemValid   = valid_q;
    assign MemAddr    = addr_q;
    assign MemWData   = wdata_q;
    assign WriteReg   = wreg_q;
    assign RegWrite   = ctrl_q.reg_write;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign MemToReg   = ctrl_q.mem_to_reg;
    assign Redirect   = redirect_q;
    assign RedirectPC = redir_pc_q;
    assign TakenCount = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_ex_mem_stage;

    logic        Clk;
    logic        Rst;
    logic        ExValid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [2:0]  BranchType;
    logic [31:0] BranchTarget;
    logic [31:0] StoreData;
    logic [4:0]  WriteRegIn;
    logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn;
    logic        MemStall;

    logic        ExReady, MemValid, RegWrite, MemRead, MemWrite, MemToReg, Redirect;
    logic [31:0] MemAddr, MemWData, RedirectPC;
    logic [4:0]  WriteReg;
    logic [15:0] TakenCount;

    logic        s_ExReady, s_MemValid, s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg, s_Redirect;
    logic [31:0] s_MemAddr, s_MemWData, s_RedirectPC;
    logic [4:0]  s_WriteReg;
    logic [1:0]  s_TakenCount;

    int checks   = 0;
    int failures = 0;

    ex_mem_stage dut (
        .Clk(Clk), .Rst(Rst), .ExValid(ExValid), .ExReady(ExReady),
        .ALUResult(ALUResult), .Zero(Zero), .BranchType(BranchType),
        .BranchTarget(BranchTarget), .StoreData(StoreData), .WriteRegIn(WriteRegIn),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemToRegIn(MemToRegIn), .MemStall(MemStall), .MemValid(MemValid),
        .MemAddr(MemAddr), .MemWData(MemWData), .WriteReg(WriteReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .TakenCount(TakenCount)
    );

    ex_mem_stage #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .ExValid(ExValid), .ExReady(s_ExReady),
        .ALUResult(ALUResult), .Zero(Zero), .BranchType(BranchType),
        .BranchTarget(BranchTarget), .StoreData(StoreData), .WriteRegIn(WriteRegIn),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemToRegIn(MemToRegIn), .MemStall(MemStall), .MemValid(s_MemValid),
        .MemAddr(s_MemAddr), .MemWData(s_MemWData), .WriteReg(s_WriteReg),
        .RegWrite(s_RegWrite), .MemRead(s_MemRead), .MemWrite(s_MemWrite),
        .MemToReg(s_MemToReg), .Redirect(s_Redirect), .RedirectPC(s_RedirectPC),
        .TakenCount(s_TakenCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_add(input logic [31:0] alu, input logic [4:0] wreg);
        ExValid    = 1'b1;
        BranchType = 3'd0;
        Zero       = 1'b0;
        ALUResult  = alu;
        WriteRegIn = wreg;
        RegWriteIn = 1'b1;
        MemReadIn  = 1'b0;
        MemWriteIn = 1'b0;
        MemToRegIn = 1'b0;
    endtask

    task automatic drive_br(input logic [2:0] bt, input logic z, input logic [31:0] tgt);
        ExValid      = 1'b1;
        BranchType   = bt;
        Zero         = z;
        BranchTarget = tgt;
        RegWriteIn   = 1'b0;
        MemReadIn    = 1'b0;
        MemWriteIn   = 1'b0;
        MemToRegIn   = 1'b0;
    endtask

    initial begin
        // Reset held with random inputs
        Rst          = 1'b0;
        ExValid      = 1'($urandom);
        MemStall     = 1'($urandom);
        ALUResult    = $urandom;
        Zero         = 1'($urandom);
        BranchType   = 3'($urandom_range(0, 7));
        BranchTarget = $urandom;
        StoreData    = $urandom;
        WriteRegIn   = 5'($urandom);
        RegWriteIn   = 1'($urandom);
        MemReadIn    = 1'($urandom);
        MemWriteIn   = 1'($urandom);
        MemToRegIn   = 1'($urandom);
        tick();
        tick();
        check("rst_valid",    32'(MemValid), 32'd0);
        check("rst_addr",     MemAddr, 32'd0);
        check("rst_wdata",    MemWData, 32'd0);
        check("rst_wreg",     32'(WriteReg), 32'd0);
        check("rst_ctrl",     32'({RegWrite, MemRead, MemWrite, MemToReg}), 32'd0);
        check("rst_redirect", 32'(Redirect), 32'd0);
        check("rst_rpc",      RedirectPC, 32'd0);
        check("rst_cnt",      32'(TakenCount), 32'd0);

        ExValid  = 1'b0;
        MemStall = 1'b0;
        Rst      = 1'b1;
        tick();
        check("post_rst_valid", 32'(MemValid), 32'd0);
        check("post_rst_redir", 32'(Redirect), 32'd0);
        check("post_rst_cnt",   32'(TakenCount), 32'd0);

        // ALU passthrough; Zero must be ignored for BranchType NONE
        drive_add(32'd30, 5'd8);
        Zero = 1'b1;
        #1;
        check("pass_ready", 32'(ExReady), 32'd1);
        tick();
        check("pass_valid", 32'(MemValid), 32'd1);
        check("pass_addr",  MemAddr, 32'd30);
        check("pass_wreg",  32'(WriteReg), 32'd8);
        check("pass_rw",    32'(RegWrite), 32'd1);
        check("pass_mr",    32'(MemRead), 32'd0);
        check("pass_redir", 32'(Redirect), 32'd0);

        // Taken BEQ, then squash with a bubble in the middle
        drive_br(3'd1, 1'b1, 32'h0000_0040);
        ALUResult = 32'h44;
        tick();
        check("beq_redir", 32'(Redirect), 32'd1);
        check("beq_rpc",   RedirectPC, 32'h40);
        check("beq_cnt",   32'(TakenCount), 32'd1);
        check("beq_valid", 32'(MemValid), 32'd1);
        check("beq_addr",  MemAddr, 32'h44);
        drive_add(32'd100, 5'd9);
        tick();
        check("sq1_valid", 32'(MemValid), 32'd0);
        check("sq1_rw",    32'(RegWrite), 32'd0);
        check("sq1_redir", 32'(Redirect), 32'd0);
        ExValid = 1'b0;
        tick();
        check("bub_valid", 32'(MemValid), 32'd0);
        // Last squashed slot carries a jump: it must be discarded
        drive_br(3'd5, 1'b0, 32'h999);
        RegWriteIn = 1'b1;
        tick();
        check("sq2_valid", 32'(MemValid), 32'd0);
        check("sq2_rw",    32'(RegWrite), 32'd0);
        check("sq2_redir", 32'(Redirect), 32'd0);
        check("sq2_cnt",   32'(TakenCount), 32'd1);
        drive_add(32'd102, 5'd10);
        tick();
        check("add3_valid", 32'(MemValid), 32'd1);
        check("add3_addr",  MemAddr, 32'd102);
        check("add3_wreg",  32'(WriteReg), 32'd10);
        check("add3_rw",    32'(RegWrite), 32'd1);
        check("add3_redir", 32'(Redirect), 32'd0);

        // Not-taken BNE, then a store that must not be squashed
        drive_br(3'd2, 1'b0, 32'h80);
        ALUResult = 32'h50;
        tick();
        check("bne_redir", 32'(Redirect), 32'd0);
        check("bne_cnt",   32'(TakenCount), 32'd1);
        check("bne_valid", 32'(MemValid), 32'd1);
        drive_add(32'h200, 5'd0);
        RegWriteIn = 1'b0;
        MemWriteIn = 1'b1;
        StoreData  = 32'hDEAD_BEEF;
        tick();
        check("sw_valid", 32'(MemValid), 32'd1);
        check("sw_mw",    32'(MemWrite), 32'd1);
        check("sw_rw",    32'(RegWrite), 32'd0);
        check("sw_wdata", MemWData, 32'hDEAD_BEEF);
        check("sw_addr",  MemAddr, 32'h200);
        check("sw_rpc",   RedirectPC, 32'h40);

        // Taken BGTZ (load), then a 3-cycle stall
        drive_br(3'd3, 1'b1, 32'h100);
        ALUResult  = 32'h300;
        WriteRegIn = 5'd4;
        RegWriteIn = 1'b1;
        MemReadIn  = 1'b1;
        MemToRegIn = 1'b1;
        tick();
        check("bgtz_redir", 32'(Redirect), 32'd1);
        check("bgtz_rpc",   RedirectPC, 32'h100);
        check("bgtz_cnt",   32'(TakenCount), 32'd2);
        check("bgtz_scnt",  32'(s_TakenCount), 32'd2);
        check("bgtz_valid", 32'(MemValid), 32'd1);
        check("bgtz_mr",    32'(MemRead), 32'd1);
        check("bgtz_m2r",   32'(MemToReg), 32'd1);
        MemStall = 1'b1;
        drive_add(32'h999, 5'd7);
        #1;
        check("stall_ready", 32'(ExReady), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(MemValid), 32'd1);
            check("stall_addr",  MemAddr, 32'h300);
            check("stall_mr",    32'(MemRead), 32'd1);
            check("stall_wreg",  32'(WriteReg), 32'd4);
            check("stall_redir", 32'(Redirect), 32'd0);
            check("stall_cnt",   32'(TakenCount), 32'd2);
        end
        MemStall = 1'b0;
        drive_add(32'd110, 5'd11);
        tick();
        check("psq1_valid", 32'(MemValid), 32'd0);
        check("psq1_redir", 32'(Redirect), 32'd0);
        drive_add(32'd111, 5'd12);
        tick();
        check("psq2_valid", 32'(MemValid), 32'd0);
        check("psq2_rw",    32'(RegWrite), 32'd0);
        drive_add(32'd112, 5'd13);
        tick();
        check("psq3_valid", 32'(MemValid), 32'd1);
        check("psq3_addr",  MemAddr, 32'd112);

        // Reserved BranchType 6 acts as NONE even with Zero=1
        drive_br(3'd6, 1'b1, 32'h7777);
        tick();
        check("bt6_redir", 32'(Redirect), 32'd0);
        check("bt6_valid", 32'(MemValid), 32'd1);
        check("bt6_cnt",   32'(TakenCount), 32'd2);

        // Back-to-back jumps separated by exactly SQUASH_DEPTH squashed slots
        for (int i = 0; i < 5; i++) begin
            drive_br(3'd5, 1'b0, 32'h1000 + 32'(i * 4));
            tick();
            check("j_redir", 32'(Redirect), 32'd1);
            check("j_rpc",   RedirectPC, 32'h1000 + 32'(i * 4));
            check("j_cnt",   32'(TakenCount), 32'(3 + i));
            check("j_scnt",  32'(s_TakenCount), 32'd3);
            drive_add(32'd200, 5'd1);
            tick();
            check("j_sq1_redir", 32'(Redirect), 32'd0);
            check("j_sq1_valid", 32'(MemValid), 32'd0);
            tick();
            check("j_sq2_valid", 32'(MemValid), 32'd0);
        end

        // Reset asserted mid-squash
        drive_br(3'd5, 1'b0, 32'h2000);
        tick();
        check("pre_rst_cnt", 32'(TakenCount), 32'd8);
        drive_add(32'd300, 5'd2);
        tick();
        check("pre_rst_valid", 32'(MemValid), 32'd0);
        Rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(MemValid), 32'd0);
        check("mid_rst_redir", 32'(Redirect), 32'd0);
        check("mid_rst_cnt",   32'(TakenCount), 32'd0);
        check("mid_rst_scnt",  32'(s_TakenCount), 32'd0);
        check("mid_rst_rpc",   RedirectPC, 32'd0);
        tick();
        Rst = 1'b1;
        drive_add(32'h55, 5'd3);
        tick();
        check("after_rst_valid", 32'(MemValid), 32'd1);
        check("after_rst_addr",  MemAddr, 32'h55);
        check("after_rst_redir", 32'(Redirect), 32'd0);
        check("after_rst_cnt",   32'(TakenCount), 32'd0);
        drive_br(3'd4, 1'b1, 32'h3000);
        tick();
        check("blez_redir", 32'(Redirect), 32'd1);
        check("blez_rpc",   RedirectPC, 32'h3000);
        check("blez_cnt",   32'(TakenCount), 32'd1);
        ExValid = 1'b0;
        tick();
        check("final_redir", 32'(Redirect), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
